// File: rtl/stage_execute_muldiv.sv
// RV32M/RV64M multiply/divide execute unit: pipelined multiplier plus an
// iterative radix-2 restoring divider, sharing one completion port to the ROB.
module stage_execute_muldiv #(
   parameter int XLEN       = 32,
   parameter int MUL_STAGES = 3,
   parameter int ROB_IDX_W  = 4,
   parameter int RD_W       = 5
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 in_valid,
   output logic                 out_ready,
   input  logic [2:0]           in_funct3,
   input  logic [XLEN-1:0]      in_operand1,
   input  logic [XLEN-1:0]      in_operand2,
   input  logic [RD_W-1:0]      in_rd,
   input  logic [ROB_IDX_W-1:0] in_complete_idx,
   input  logic                 in_flush,
   output logic                 out_complete,
   output logic [XLEN-1:0]      out_result,
   output logic [RD_W-1:0]      out_rd,
   output logic [ROB_IDX_W-1:0] out_complete_idx,
   output logic                 out_stall
);

   localparam int CNT_W = $clog2(XLEN);

   // Handshake: an op moves when in_valid & out_ready & ~in_flush at a rising edge.
   typedef enum logic [1:0] {S_IDLE, S_ITER, S_FIX} div_state_t;
   div_state_t state, state_next;

   logic accept, mul_accept, div_accept;
   logic mul_busy, mul_done, div_done;

   assign accept     = in_valid & out_ready & ~in_flush;
   assign mul_accept = accept & ~in_funct3[2];
   assign div_accept = accept & in_funct3[2];

   // ---------------- multiplier ----------------
   logic                    op1_signed, op2_signed;
   logic [XLEN:0]           mul_a, mul_b;
   logic signed [2*XLEN+1:0] mul_a_w, mul_b_w, mul_prod;
   logic [XLEN-1:0]         mul_sel;

   assign op1_signed = (in_funct3[1:0] == 2'b01) | (in_funct3[1:0] == 2'b10);
   assign op2_signed = (in_funct3[1:0] == 2'b01);
   assign mul_a      = {op1_signed & in_operand1[XLEN-1], in_operand1};
   assign mul_b      = {op2_signed & in_operand2[XLEN-1], in_operand2};
   assign mul_a_w    = {{(XLEN+1){mul_a[XLEN]}}, mul_a};
   assign mul_b_w    = {{(XLEN+1){mul_b[XLEN]}}, mul_b};
   assign mul_prod   = mul_a_w * mul_b_w;
   assign mul_sel    = (in_funct3[1:0] == 2'b00) ? mul_prod[XLEN-1:0]
                                                 : mul_prod[2*XLEN-1:XLEN];

   logic [MUL_STAGES-1:0] mul_v;
   logic [XLEN-1:0]       mul_res [MUL_STAGES];
   logic [RD_W-1:0]       mul_rd  [MUL_STAGES];
   logic [ROB_IDX_W-1:0]  mul_idx [MUL_STAGES];

   always_ff @(posedge clk) begin
      if (reset) begin
         mul_v <= '0;
         for (int i = 0; i < MUL_STAGES; i++) begin
            mul_res[i] <= '0;
            mul_rd[i]  <= '0;
            mul_idx[i] <= '0;
         end
      end else begin
         mul_v[0]   <= mul_accept;
         mul_res[0] <= mul_sel;
         mul_rd[0]  <= in_rd;
         mul_idx[0] <= in_complete_idx;
         for (int i = 1; i < MUL_STAGES; i++) begin
            mul_v[i]   <= mul_v[i-1];
            mul_res[i] <= mul_res[i-1];
            mul_rd[i]  <= mul_rd[i-1];
            mul_idx[i] <= mul_idx[i-1];
         end
         if (in_flush) mul_v <= '0;
      end
   end

   assign mul_busy = |mul_v;
   assign mul_done = mul_v[MUL_STAGES-1];

   // ---------------- divider datapath ----------------
   logic                 div_signed, div_zero, div_ovf, neg1, neg2;
   logic [XLEN-1:0]      abs1, abs2;
   logic [XLEN-1:0]      div_quot, div_rem, div_dsr;
   logic [CNT_W-1:0]     div_cnt;
   logic                 div_neg_q, div_neg_r, div_is_rem;
   logic [RD_W-1:0]      div_rd;
   logic [ROB_IDX_W-1:0] div_idx;
   logic [XLEN:0]        rem_sh, rem_diff;
   logic                 rem_ge;

   assign div_signed = ~in_funct3[0];
   assign div_zero   = (in_operand2 == '0);
   assign div_ovf    = div_signed & (in_operand1 == {1'b1, {(XLEN-1){1'b0}}}) & (&in_operand2);
   assign neg1       = div_signed & in_operand1[XLEN-1];
   assign neg2       = div_signed & in_operand2[XLEN-1];
   assign abs1       = neg1 ? -in_operand1 : in_operand1;
   assign abs2       = neg2 ? -in_operand2 : in_operand2;

   // Dividend bits shift out of div_quot as quotient bits shift in.
   assign rem_sh   = {div_rem, div_quot[XLEN-1]};
   assign rem_diff = rem_sh - {1'b0, div_dsr};
   assign rem_ge   = (rem_sh >= {1'b0, div_dsr});

   always_ff @(posedge clk) begin
      if (reset) begin
         div_quot   <= '0;
         div_rem    <= '0;
         div_dsr    <= '0;
         div_cnt    <= '0;
         div_neg_q  <= 1'b0;
         div_neg_r  <= 1'b0;
         div_is_rem <= 1'b0;
         div_rd     <= '0;
         div_idx    <= '0;
      end else if (div_accept) begin
         div_is_rem <= in_funct3[1];
         div_rd     <= in_rd;
         div_idx    <= in_complete_idx;
         div_cnt    <= CNT_W'(XLEN-1);
         div_dsr    <= abs2;
         if (div_zero) begin
            div_quot  <= '1;
            div_rem   <= in_operand1;
            div_neg_q <= 1'b0;
            div_neg_r <= 1'b0;
         end else if (div_ovf) begin
            div_quot  <= in_operand1;
            div_rem   <= '0;
            div_neg_q <= 1'b0;
            div_neg_r <= 1'b0;
         end else begin
            div_quot  <= abs1;
            div_rem   <= '0;
            div_neg_q <= neg1 ^ neg2;
            div_neg_r <= neg1;
         end
      end else if (state == S_ITER) begin
         div_rem  <= rem_ge ? rem_diff[XLEN-1:0] : rem_sh[XLEN-1:0];
         div_quot <= {div_quot[XLEN-2:0], rem_ge};
         div_cnt  <= div_cnt - 1'b1;
      end
   end

   // ---------------- divider FSM ----------------
   always_ff @(posedge clk) begin
      if (reset) state <= S_IDLE;
      else       state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         S_IDLE:  if (div_accept) state_next = (div_zero | div_ovf) ? S_FIX : S_ITER;
         S_ITER:  if (div_cnt == '0) state_next = S_FIX;
         S_FIX:   state_next = S_IDLE;
         default: state_next = S_IDLE;
      endcase
      if (in_flush) state_next = S_IDLE;
   end

   logic [XLEN-1:0] div_q_fin, div_r_fin;
   assign div_q_fin = div_neg_q ? -div_quot : div_quot;
   assign div_r_fin = div_neg_r ? -div_rem  : div_rem;
   assign div_done  = (state == S_FIX);

   // Completion is masked during a flush cycle so a killed op never reaches the ROB.
   always_comb begin
      out_ready        = (state == S_IDLE) & (~in_funct3[2] | ~mul_busy);
      out_stall        = in_valid & ~out_ready;
      out_complete     = (mul_done | div_done) & ~in_flush;
      out_result       = '0;
      out_rd           = '0;
      out_complete_idx = '0;
      if (mul_done) begin
         out_result       = mul_res[MUL_STAGES-1];
         out_rd           = mul_rd[MUL_STAGES-1];
         out_complete_idx = mul_idx[MUL_STAGES-1];
      end else if (div_done) begin
         out_result       = div_is_rem ? div_r_fin : div_q_fin;
         out_rd           = div_rd;
         out_complete_idx = div_idx;
      end
   end

   logic unused_bits;
   assign unused_bits = &{1'b0, mul_prod[2*XLEN+1:2*XLEN], rem_diff[XLEN]};

   a_no_collision: assert property (@(posedge clk) disable iff (reset) !(mul_done && div_done));

endmodule

// File: tb/tb_stage_execute_muldiv.sv
// Directed bench for stage_execute_muldiv (XLEN=32, MUL_STAGES=3): latency,
// results, stalls, special divides, flush and reset behaviour.
module tb_stage_execute_muldiv;

   localparam logic [2:0] F_MUL = 3'b000, F_MULH = 3'b001, F_MULHSU = 3'b010, F_MULHU = 3'b011;
   localparam logic [2:0] F_DIV = 3'b100, F_DIVU = 3'b101, F_REM = 3'b110, F_REMU = 3'b111;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        in_valid = 1'b0;
   logic        out_ready;
   logic [2:0]  in_funct3 = 3'b000;
   logic [31:0] in_operand1 = '0;
   logic [31:0] in_operand2 = '0;
   logic [4:0]  in_rd = '0;
   logic [3:0]  in_complete_idx = '0;
   logic        in_flush = 1'b0;
   logic        out_complete;
   logic [31:0] out_result;
   logic [4:0]  out_rd;
   logic [3:0]  out_complete_idx;
   logic        out_stall;

   int checks = 0;
   int errors = 0;

   stage_execute_muldiv #(.XLEN(32), .MUL_STAGES(3), .ROB_IDX_W(4), .RD_W(5)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .out_ready(out_ready),
      .in_funct3(in_funct3), .in_operand1(in_operand1), .in_operand2(in_operand2),
      .in_rd(in_rd), .in_complete_idx(in_complete_idx), .in_flush(in_flush),
      .out_complete(out_complete), .out_result(out_result), .out_rd(out_rd),
      .out_complete_idx(out_complete_idx), .out_stall(out_stall)
   );

   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Inputs change on the falling edge; outputs are sampled 1 time unit later.
   task automatic drive(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input logic [3:0] idx);
      in_valid = 1'b1; in_funct3 = f; in_operand1 = a; in_operand2 = b;
      in_rd = rd; in_complete_idx = idx;
   endtask

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic issue(input string tag, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd, input logic [3:0] idx);
      @(negedge clk);
      drive(f, a, b, rd, idx);
      #1;
      check({tag, "_ready"}, out_ready, 1);
      @(negedge clk);
      in_valid = 1'b0;
      #1;
   endtask

   // Called one cycle after the accept cycle; k counts cycles since accept.
   task automatic expect_done(input string tag, input int lat, input logic [31:0] res,
                              input logic [4:0] rd, input logic [3:0] idx);
      int k;
      k = 1;
      while (out_complete !== 1'b1 && k < lat + 5) begin
         step();
         k++;
      end
      check({tag, "_lat"}, k, lat);
      check({tag, "_res"}, out_result, res);
      check({tag, "_rd"}, out_rd, rd);
      check({tag, "_idx"}, out_complete_idx, idx);
      step();
      check({tag, "_pulse"}, out_complete, 0);
      check({tag, "_ready_after"}, out_ready, 1);
   endtask

   task automatic no_complete(input string tag, input int n);
      int seen;
      seen = 0;
      for (int i = 0; i < n; i++) begin
         step();
         if (out_complete === 1'b1) seen++;
      end
      check(tag, seen, 0);
   endtask

   int stalls, saw_mul, got_ready;

   initial begin
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      #1;
      check("rst_ready", out_ready, 1);
      check("rst_complete", out_complete, 0);
      check("rst_result", out_result, 0);
      check("rst_rd", out_rd, 0);
      check("rst_idx", out_complete_idx, 0);

      // Back-to-back multiplies.
      @(negedge clk); drive(F_MUL, 32'd7, 32'hFFFF_FFFD, 5'd1, 4'd1); #1;
      check("b2b_ready0", out_ready, 1);
      @(negedge clk); drive(F_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, 4'd2); #1;
      check("b2b_ready1", out_ready, 1);
      @(negedge clk); in_valid = 1'b0; #1;
      check("b2b_early", out_complete, 0);
      step();
      check("b2b_c0", out_complete, 1);
      check("b2b_r0", out_result, 32'hFFFF_FFEB);
      check("b2b_i0", out_complete_idx, 1);
      step();
      check("b2b_c1", out_complete, 1);
      check("b2b_r1", out_result, 32'hFFFF_FFFE);
      check("b2b_i1", out_complete_idx, 2);
      step();
      check("b2b_c2", out_complete, 0);

      issue("mulh", F_MULH, 32'h8000_0000, 32'h8000_0000, 5'd3, 4'd3);
      expect_done("mulh", 3, 32'h4000_0000, 5'd3, 4'd3);
      issue("mulhsu", F_MULHSU, 32'hFFFF_FFFF, 32'd2, 5'd4, 4'd4);
      expect_done("mulhsu", 3, 32'hFFFF_FFFF, 5'd4, 4'd4);
      issue("mulhu_small", F_MULHU, 32'd3, 32'd5, 5'd5, 4'd5);
      expect_done("mulhu_small", 3, 32'h0, 5'd5, 4'd5);

      // Signed divide with a stalled second op.
      issue("div_neg", F_DIV, 32'hFFFF_FFF9, 32'd2, 5'd6, 4'd6);
      in_valid = 1'b1; in_funct3 = F_MUL; #1;
      check("div_stall", out_stall, 1);
      in_valid = 1'b0; #1;
      expect_done("div_neg", 33, 32'hFFFF_FFFD, 5'd6, 4'd6);
      issue("rem_neg", F_REM, 32'hFFFF_FFF9, 32'd2, 5'd7, 4'd7);
      expect_done("rem_neg", 33, 32'hFFFF_FFFF, 5'd7, 4'd7);
      issue("divu", F_DIVU, 32'd100, 32'd7, 5'd8, 4'd8);
      expect_done("divu", 33, 32'd14, 5'd8, 4'd8);
      issue("remu", F_REMU, 32'd100, 32'd7, 5'd9, 4'd9);
      expect_done("remu", 33, 32'd2, 5'd9, 4'd9);
      issue("divu_big", F_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 5'd10, 4'd10);
      expect_done("divu_big", 33, 32'd0, 5'd10, 4'd10);

      // Special divides.
      issue("divu_z", F_DIVU, 32'd5, 32'd0, 5'd11, 4'd11);
      expect_done("divu_z", 1, 32'hFFFF_FFFF, 5'd11, 4'd11);
      issue("rem_z", F_REM, 32'd5, 32'd0, 5'd12, 4'd12);
      expect_done("rem_z", 1, 32'd5, 5'd12, 4'd12);
      issue("div_ovf", F_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13, 4'd13);
      expect_done("div_ovf", 1, 32'h8000_0000, 5'd13, 4'd13);
      issue("rem_ovf", F_REM, 32'h8000_0000, 32'hFFFF_FFFF, 5'd14, 4'd14);
      expect_done("rem_ovf", 1, 32'h0, 5'd14, 4'd14);

      // MUL followed by DIV: DIV waits for the pipeline to drain.
      @(negedge clk); drive(F_MUL, 32'd6, 32'd7, 5'd15, 4'd3); #1;
      @(negedge clk); drive(F_DIV, 32'd20, 32'd3, 5'd16, 4'd4); #1;
      check("mdiv_stall", out_stall, 1);
      stalls = 0; saw_mul = 0; got_ready = 0;
      for (int i = 0; i < 10 && got_ready == 0; i++) begin
         if (out_complete === 1'b1) begin
            saw_mul++;
            check("mdiv_mul_res", out_result, 32'd42);
            check("mdiv_mul_idx", out_complete_idx, 4'd3);
         end
         if (out_ready === 1'b1) got_ready = 1;
         else begin
            stalls++;
            step();
         end
      end
      check("mdiv_got_ready", got_ready, 1);
      check("mdiv_stalls", stalls, 3);
      check("mdiv_saw_mul", saw_mul, 1);
      @(negedge clk); in_valid = 1'b0; #1;
      expect_done("mdiv_div", 33, 32'd6, 5'd16, 4'd4);

      // Flush while the divider is mid-iteration, with an op presented in the flush cycle.
      issue("fl_div", F_DIVU, 32'd1000, 32'd3, 5'd17, 4'd5);
      repeat (16) step();
      @(negedge clk);
      in_flush = 1'b1;
      drive(F_MUL, 32'd2, 32'd2, 5'd18, 4'd6);
      #1;
      check("fl_div_cycle", out_complete, 0);
      @(negedge clk);
      in_flush = 1'b0; in_valid = 1'b0;
      #1;
      check("fl_div_ready", out_ready, 1);
      check("fl_div_after", out_complete, 0);
      no_complete("fl_div_quiet", 40);

      // Flush with multiplies in flight; the op offered during flush must be dropped.
      @(negedge clk); drive(F_MUL, 32'd3, 32'd3, 5'd19, 4'd7); #1;
      @(negedge clk); drive(F_MUL, 32'd4, 32'd4, 5'd20, 4'd8); #1;
      @(negedge clk); in_valid = 1'b0; #1;
      @(negedge clk);
      in_flush = 1'b1;
      drive(F_MUL, 32'd5, 32'd5, 5'd21, 4'd9);
      #1;
      check("fl_mul_cycle", out_complete, 0);
      @(negedge clk);
      in_flush = 1'b0; in_valid = 1'b0;
      #1;
      check("fl_mul_after", out_complete, 0);
      check("fl_mul_ready", out_ready, 1);
      no_complete("fl_mul_quiet", 8);

      // Reset in the middle of a divide.
      issue("rs_div", F_DIV, 32'd999, 32'd4, 5'd22, 4'd10);
      repeat (16) step();
      @(negedge clk); reset = 1'b1;
      @(negedge clk); reset = 1'b0; #1;
      check("rs_ready", out_ready, 1);
      check("rs_complete", out_complete, 0);
      check("rs_result", out_result, 0);
      no_complete("rs_quiet", 40);

      issue("post", F_MUL, 32'd3, 32'd5, 5'd23, 4'd11);
      expect_done("post", 3, 32'd15, 5'd23, 4'd11);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
